// File: rtl/icu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : icu_sequencer
// Brief    : Fetch/sequence controller for the 1-bit ICU; executes JMP, RTN,
//            SKZ, NOPO and NOPF locally and forwards every opcode to the ICU.
// Revision : 1.0
// ============================================================================
module icu_sequencer #(
  parameter  int ADDR_W = 8,
  localparam int WORD_W = ADDR_W + 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              result,
  output logic [3:0]        I,
  output logic [ADDR_W-1:0] io_addr,
  output logic              flag_0,
  output logic              flag_f,
  output logic              jmp,
  output logic              rtn,
  output logic              busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] EXEC  = 2'd2;

  localparam logic [3:0] OP_NOPO = 4'h0;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_RTN  = 4'hD;
  localparam logic [3:0] OP_SKZ  = 4'hE;
  localparam logic [3:0] OP_NOPF = 4'hF;

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] ret_addr;
  logic [WORD_W-1:0] ir;
  logic              skip;

  logic              in_exec;
  logic              live;
  logic [3:0]        ir_op;
  logic [ADDR_W-1:0] ir_operand;
  logic [ADDR_W-1:0] pc_inc;

  assign in_exec    = (state == EXEC);
  // A pending skip suppresses the opcode, its pulse and its control effect.
  assign live       = in_exec & ~skip;
  assign ir_op      = ir[WORD_W-1 -: 4];
  assign ir_operand = ir[ADDR_W-1:0];
  assign pc_inc     = pc + {{(ADDR_W-1){1'b0}}, 1'b1};

  assign mem_req  = (state == FETCH);
  assign mem_addr = pc;
  assign busy     = (state != IDLE);
  assign I        = live ? ir_op : 4'h0;
  assign io_addr  = in_exec ? ir_operand : '0;
  assign flag_0   = live & (ir_op == OP_NOPO);
  assign flag_f   = live & (ir_op == OP_NOPF);
  assign jmp      = live & (ir_op == OP_JMP);
  assign rtn      = live & (ir_op == OP_RTN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= '0;
      ret_addr <= '0;
      ir       <= '0;
      skip     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (run) begin
            state <= FETCH;
          end
        end
        FETCH: begin
          // run is not consulted here so an issued fetch always completes.
          if (mem_ack) begin
            ir    <= mem_rdata;
            state <= EXEC;
          end
        end
        EXEC: begin
          state <= run ? FETCH : IDLE;
          skip  <= 1'b0;
          pc    <= pc_inc;
          if (!skip) begin
            if (ir_op == OP_JMP) begin
              ret_addr <= pc_inc;
              pc       <= ir_operand;
            end else if (ir_op == OP_RTN) begin
              pc <= ret_addr;
            end else if (ir_op == OP_SKZ) begin
              skip <= ~result;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_icu_sequencer.sv
`default_nettype none
// Testbench for icu_sequencer: directed scenarios followed by a randomized
// program run, checked against an instruction-level reference model.
module tb_icu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack;
  logic [11:0] mem_rdata;
  logic        result;
  logic [3:0]  I;
  logic [7:0]  io_addr;
  logic        flag_0;
  logic        flag_f;
  logic        jmp;
  logic        rtn;
  logic        busy;

  icu_sequencer #(.ADDR_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .result    (result),
    .I         (I),
    .io_addr   (io_addr),
    .flag_0    (flag_0),
    .flag_f    (flag_f),
    .jmp       (jmp),
    .rtn       (rtn),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  logic [11:0] mem [256];
  logic [7:0]  m_pc;
  logic [7:0]  m_ret;
  logic        m_skip;
  int          passed = 0;
  int          total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_req"}, mem_req, 0);
    chk({tag, "_I"}, I, 0);
    chk({tag, "_io"}, io_addr, 0);
  endtask

  // One full instruction: fetch with 'waits' stall cycles, then execute.
  task automatic step(input int waits, input bit res, input bit run_v);
    logic [11:0] w;
    logic [3:0]  op;
    logic [7:0]  opnd;
    logic        live;
    run    = run_v;
    result = res;
    chk("fetch_req", mem_req, 1);
    chk("fetch_addr", mem_addr, m_pc);
    chk("fetch_I", I, 0);
    chk("fetch_io", io_addr, 0);
    for (int k = 0; k < waits; k++) begin
      mem_ack = 1'b0;
      @(negedge clk);
      chk("wait_req", mem_req, 1);
      chk("wait_addr", mem_addr, m_pc);
    end
    w         = mem[m_pc];
    mem_ack   = 1'b1;
    mem_rdata = w;
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = 12'($urandom);
    op   = w[11:8];
    opnd = w[7:0];
    live = !m_skip;
    chk("exec_busy", busy, 1);
    chk("exec_req", mem_req, 0);
    chk("exec_I", I, live ? op : 4'h0);
    chk("exec_io", io_addr, opnd);
    chk("exec_jmp", jmp, live && op == 4'hC);
    chk("exec_rtn", rtn, live && op == 4'hD);
    chk("exec_f0", flag_0, live && op == 4'h0);
    chk("exec_ff", flag_f, live && op == 4'hF);
    if (!live) begin
      m_skip = 1'b0;
      m_pc   = m_pc + 8'd1;
    end else if (op == 4'hC) begin
      m_ret = m_pc + 8'd1;
      m_pc  = opnd;
    end else if (op == 4'hD) begin
      m_pc = m_ret;
    end else begin
      if (op == 4'hE) m_skip = ~res;
      m_pc = m_pc + 8'd1;
    end
    @(negedge clk);
  endtask

  task automatic resume(input int idle_cycles);
    for (int c = 0; c < idle_cycles; c++) begin
      chk_quiet("idle");
      @(negedge clk);
    end
    run = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    run       = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    result    = 1'b0;
    m_pc      = '0;
    m_ret     = '0;
    m_skip    = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 12'($urandom);
    mem[8'h00] = 12'h105;
    mem[8'h01] = 12'h306;
    mem[8'h02] = 12'h807;
    mem[8'h03] = 12'hE00;
    mem[8'h04] = 12'hC20;
    mem[8'h20] = 12'hD00;
    mem[8'h05] = 12'hCFF;
    mem[8'hFF] = 12'h1AA;

    @(negedge clk);
    chk_quiet("reset");
    chk("reset_addr", mem_addr, 0);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_quiet("idle_after_reset");

    // Sequential fetch, a 3-cycle wait, then SKZ with result=0 skipping JMP.
    run = 1'b1;
    @(negedge clk);
    step(0, 0, 1);
    step(0, 0, 1);
    step(3, 0, 1);
    step(0, 0, 1);
    step(0, 0, 1);

    // Asynchronous reset in the middle of a stalled fetch.
    mem_ack = 1'b0;
    chk("pre_rst_req", mem_req, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_req", mem_req, 0);
    chk("rst_I", I, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst    = 1'b0;
    run    = 1'b0;
    m_pc   = '0;
    m_ret  = '0;
    m_skip = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_idle_busy", busy, 0);
    end

    // SKZ with result=1, JMP taken, RTN, jump to 0xFF and wrap to 0.
    run = 1'b1;
    @(negedge clk);
    step(0, 0, 1);
    step(0, 0, 1);
    step(0, 0, 1);
    step(0, 1, 1);
    step(0, 0, 1);
    step(1, 0, 1);
    step(0, 0, 1);
    step(0, 0, 1);
    // run dropped during FETCH: instruction completes, then IDLE and resume.
    step(2, 0, 0);
    resume(3);

    for (int n = 0; n < 300; n++) begin
      logic run_v;
      run_v = ($urandom_range(0, 7) != 0);
      step($urandom_range(0, 2), 1'($urandom), run_v);
      if (!run_v) resume($urandom_range(1, 3));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
